// File: rtl/execute_stage_muldiv.sv
// RV32IM execute stage: 1-cycle ALU plus multi-cycle MUL/DIV unit feeding the EX/MEM register.
// Latency: ALU 1 edge; M ops stall upstream and send bubbles to EX/MEM until the DONE cycle captures.
module execute_stage_muldiv #(
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic [3:0]  aluControlEX,
  input  logic [31:0] operandAEX,
  input  logic [31:0] operandBEX,
  input  logic        mulDivEnEX,
  input  logic [2:0]  mulDivOpEX,
  input  logic        loadSignalEX,
  input  logic        storeSignalEX,
  input  logic        rdWriteEnEX,
  input  logic [2:0]  loadStoreByteSelectEX,
  input  logic [4:0]  rdAddrEX,
  input  logic [1:0]  destinationSelectEX,
  input  logic [31:0] storeDataEX,
  input  logic [31:0] pcEX,
  input  logic        flushEX,
  output logic        stallEX,
  output logic [31:0] aluResultMEM,
  output logic [31:0] pcPlus4MEM,
  output logic [31:0] storeDataMEM,
  output logic        loadSignalMEM,
  output logic        storeSignalMEM,
  output logic [2:0]  loadStoreByteSelectMEM,
  output logic [4:0]  rdAddrMEM,
  output logic        rdWriteEnMEM,
  output logic [1:0]  destinationSelectMEM
);

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [2:0] MD_MUL   = 3'd0;
  localparam logic [2:0] MD_MULH  = 3'd1;
  localparam logic [2:0] MD_MULHU = 3'd3;

  localparam logic [2:0] FUNCT3_BYTE = 3'b000;
  localparam logic [1:0] WB_SEL_ALU  = 2'b00;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [5:0] DIV_STEPS = 6'(32 / DIV_BITS_PER_CYCLE);

  logic [1:0]  state;
  logic [2:0]  op_q;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvsr;
  logic        neg_q;
  logic        neg_r;
  logic [5:0]  cnt;

  logic [31:0] alu_res;
  logic [31:0] md_res;
  logic        div_signed;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] a_ext;
  logic [32:0] b_ext;
  logic signed [63:0] prod;
  logic [31:0] nq;
  logic [31:0] nr;
  logic [32:0] tr;

  assign stallEX = mulDivEnEX & (state != S_DONE) & ~flushEX;

  always_comb begin
    alu_res = '0;
    case (aluControlEX)
      ALU_ADD:    alu_res = operandAEX + operandBEX;
      ALU_SUB:    alu_res = operandAEX - operandBEX;
      ALU_SLL:    alu_res = operandAEX << operandBEX[4:0];
      ALU_SLT:    alu_res = {31'b0, $signed(operandAEX) < $signed(operandBEX)};
      ALU_SLTU:   alu_res = {31'b0, operandAEX < operandBEX};
      ALU_XOR:    alu_res = operandAEX ^ operandBEX;
      ALU_SRL:    alu_res = operandAEX >> operandBEX[4:0];
      ALU_SRA:    alu_res = $signed(operandAEX) >>> operandBEX[4:0];
      ALU_OR:     alu_res = operandAEX | operandBEX;
      ALU_AND:    alu_res = operandAEX & operandBEX;
      ALU_PASS_B: alu_res = operandBEX;
      default:    alu_res = '0;
    endcase
  end

  // Divide decode is only consumed in IDLE, where the EX inputs are the new op.
  assign div_signed = ~mulDivOpEX[0];
  assign div_zero   = (operandBEX == 32'h0);
  assign div_ovf    = div_signed & (operandAEX == 32'h8000_0000) & (operandBEX == 32'hFFFF_FFFF);
  assign a_mag      = (div_signed & operandAEX[31]) ? -operandAEX : operandAEX;
  assign b_mag      = (div_signed & operandBEX[31]) ? -operandBEX : operandBEX;

  assign a_ext = {(op_q != MD_MULHU) & quo[31], quo};
  assign b_ext = {((op_q == MD_MUL) | (op_q == MD_MULH)) & dvsr[31], dvsr};
  assign prod  = $signed(a_ext) * $signed(b_ext);

  always_comb begin
    nq = quo;
    nr = rem;
    tr = '0;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      tr = {nr, nq[31]};
      nq = {nq[30:0], 1'b0};
      if (tr >= {1'b0, dvsr}) begin
        tr    = tr - {1'b0, dvsr};
        nq[0] = 1'b1;
      end
      nr = tr[31:0];
    end
  end

  always_comb begin
    if (!op_q[2])      md_res = quo;
    else if (!op_q[1]) md_res = neg_q ? -quo : quo;
    else               md_res = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state <= S_IDLE;
      op_q  <= '0;
      quo   <= '0;
      rem   <= '0;
      dvsr  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt   <= '0;
    end else if (flushEX) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (mulDivEnEX) begin
          op_q <= mulDivOpEX;
          if (!mulDivOpEX[2]) begin
            quo   <= operandAEX;
            dvsr  <= operandBEX;
            state <= S_MUL;
          end else if (div_zero || div_ovf) begin
            // Special cases preload their answer and pass through one empty DIV cycle.
            quo   <= div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
            rem   <= div_zero ? operandAEX : 32'h0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            cnt   <= '0;
            state <= S_DIV;
          end else begin
            quo   <= a_mag;
            dvsr  <= b_mag;
            rem   <= '0;
            neg_q <= div_signed & (operandAEX[31] ^ operandBEX[31]);
            neg_r <= div_signed & operandAEX[31];
            cnt   <= DIV_STEPS;
            state <= S_DIV;
          end
        end
        S_MUL: begin
          quo   <= (op_q == MD_MUL) ? prod[31:0] : prod[63:32];
          state <= S_DONE;
        end
        S_DIV: begin
          if (cnt == 6'd0) begin
            state <= S_DONE;
          end else begin
            quo <= nq;
            rem <= nr;
            cnt <= cnt - 6'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      aluResultMEM           <= '0;
      pcPlus4MEM             <= '0;
      storeDataMEM           <= '0;
      loadSignalMEM          <= 1'b0;
      storeSignalMEM         <= 1'b0;
      loadStoreByteSelectMEM <= FUNCT3_BYTE;
      rdAddrMEM              <= '0;
      rdWriteEnMEM           <= 1'b0;
      destinationSelectMEM   <= WB_SEL_ALU;
    end else if (flushEX || (mulDivEnEX && state != S_DONE)) begin
      loadSignalMEM  <= 1'b0;
      storeSignalMEM <= 1'b0;
      rdWriteEnMEM   <= 1'b0;
    end else begin
      aluResultMEM           <= mulDivEnEX ? md_res : alu_res;
      pcPlus4MEM             <= pcEX + 32'd4;
      storeDataMEM           <= storeDataEX;
      loadSignalMEM          <= loadSignalEX;
      storeSignalMEM         <= storeSignalEX;
      loadStoreByteSelectMEM <= loadStoreByteSelectEX;
      rdAddrMEM              <= rdAddrEX;
      rdWriteEnMEM           <= rdWriteEnEX;
      destinationSelectMEM   <= destinationSelectEX;
    end
  end

endmodule

// File: tb/tb_execute_stage_muldiv.sv
// Randomized bench for execute_stage_muldiv against an arithmetic reference model.
module tb_execute_stage_muldiv;
  localparam int N = 1;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  logic        clk = 1'b0;
  logic        arstn;
  logic [3:0]  aluControlEX;
  logic [31:0] operandAEX, operandBEX;
  logic        mulDivEnEX;
  logic [2:0]  mulDivOpEX;
  logic        loadSignalEX, storeSignalEX, rdWriteEnEX;
  logic [2:0]  loadStoreByteSelectEX;
  logic [4:0]  rdAddrEX;
  logic [1:0]  destinationSelectEX;
  logic [31:0] storeDataEX, pcEX;
  logic        flushEX;
  logic        stallEX;
  logic [31:0] aluResultMEM, pcPlus4MEM, storeDataMEM;
  logic        loadSignalMEM, storeSignalMEM, rdWriteEnMEM;
  logic [2:0]  loadStoreByteSelectMEM;
  logic [4:0]  rdAddrMEM;
  logic [1:0]  destinationSelectMEM;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  execute_stage_muldiv #(.DIV_BITS_PER_CYCLE(N)) dut (
    .clk(clk), .arstn(arstn),
    .aluControlEX(aluControlEX), .operandAEX(operandAEX), .operandBEX(operandBEX),
    .mulDivEnEX(mulDivEnEX), .mulDivOpEX(mulDivOpEX),
    .loadSignalEX(loadSignalEX), .storeSignalEX(storeSignalEX), .rdWriteEnEX(rdWriteEnEX),
    .loadStoreByteSelectEX(loadStoreByteSelectEX), .rdAddrEX(rdAddrEX),
    .destinationSelectEX(destinationSelectEX), .storeDataEX(storeDataEX), .pcEX(pcEX),
    .flushEX(flushEX), .stallEX(stallEX),
    .aluResultMEM(aluResultMEM), .pcPlus4MEM(pcPlus4MEM), .storeDataMEM(storeDataMEM),
    .loadSignalMEM(loadSignalMEM), .storeSignalMEM(storeSignalMEM),
    .loadStoreByteSelectMEM(loadStoreByteSelectMEM), .rdAddrMEM(rdAddrMEM),
    .rdWriteEnMEM(rdWriteEnMEM), .destinationSelectMEM(destinationSelectMEM)
  );

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    logic [63:0] t;
    int sh;
    sa = longint'($signed(a));
    sh = int'(b % 32);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << sh;
      4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> sh;
      4'd7:  begin t = sa >>> sh; return t[31:0]; end
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_stalls(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return 2;
    if (b == 0) return 2;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 32 / N + 2;
  endfunction

  task automatic drive(input logic md, input logic [2:0] mop, input logic [3:0] aop,
                       input logic [31:0] a, input logic [31:0] b);
    mulDivEnEX            = md;
    mulDivOpEX            = mop;
    aluControlEX          = aop;
    operandAEX            = a;
    operandBEX            = b;
    rdAddrEX              = 5'($urandom_range(1, 31));
    rdWriteEnEX           = 1'b1;
    loadSignalEX          = 1'b0;
    storeSignalEX         = 1'b0;
    loadStoreByteSelectEX = 3'($urandom_range(1, 7));
    destinationSelectEX   = 2'($urandom_range(1, 3));
    storeDataEX           = $urandom;
    pcEX                  = $urandom & 32'hFFFF_FFFC;
  endtask

  // Issues one M op and holds it until the result lands; returns what was observed.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int stalls, output bit bub_ok, output logic wen);
    @(posedge clk); #1;
    drive(1'b1, op, ALU_ADD, a, b);
    stalls = 0;
    bub_ok = 1'b1;
    @(negedge clk);
    while (stallEX === 1'b1 && stalls < 200) begin
      stalls++;
      @(negedge clk);
      if (rdWriteEnMEM !== 1'b0) bub_ok = 1'b0;
    end
    @(posedge clk); #1;
    res = aluResultMEM;
    wen = rdWriteEnMEM;
    drive(1'b0, 3'd0, ALU_ADD, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    arstn   = 1'b0;
    flushEX = 1'b0;
    drive(1'b0, 3'd0, ALU_ADD, $urandom, $urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (aluResultMEM !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", aluResultMEM); end
    total++; if ({pcPlus4MEM, storeDataMEM} !== 64'd0) begin bad++; $display("FAIL reset_pc_sd got=%h/%h exp=0", pcPlus4MEM, storeDataMEM); end
    total++; if ({loadSignalMEM, storeSignalMEM, rdWriteEnMEM, rdAddrMEM} !== 8'd0) begin
      bad++; $display("FAIL reset_ctrl got=%b%b%b rd=%0d exp=0", loadSignalMEM, storeSignalMEM, rdWriteEnMEM, rdAddrMEM); end
    total++; if ({loadStoreByteSelectMEM, destinationSelectMEM} !== 5'd0) begin
      bad++; $display("FAIL reset_sel got=%0d/%0d exp=0/0", loadStoreByteSelectMEM, destinationSelectMEM); end
    total++; if (stallEX !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stallEX); end
    arstn = 1'b1;
  endtask

  task automatic test_alu();
    logic [3:0]  op;
    logic [31:0] a, b, pc;
    logic        st;
    for (int i = 0; i < 21; i++) begin
      if (i == 0) begin op = ALU_ADD; a = 32'd5; b = 32'd7; end
      else begin op = 4'($urandom_range(0, 10)); a = $urandom; b = $urandom; end
      @(posedge clk); #1;
      drive(1'b0, 3'($urandom), op, a, b);
      pc = pcEX;
      @(negedge clk);
      st = stallEX;
      @(posedge clk); #1;
      total++; if (aluResultMEM !== ref_alu(op, a, b)) begin
        bad++; $display("FAIL alu op=%0d a=%h b=%h got=%h exp=%h", op, a, b, aluResultMEM, ref_alu(op, a, b)); end
      total++; if (st !== 1'b0) begin bad++; $display("FAIL alu_stall op=%0d got=%b exp=0", op, st); end
      total++; if (pcPlus4MEM !== pc + 32'd4 || rdWriteEnMEM !== 1'b1) begin
        bad++; $display("FAIL alu_side got=%h/%b exp=%h/1", pcPlus4MEM, rdWriteEnMEM, pc + 32'd4); end
    end
  endtask

  task automatic test_muldiv(input int count, input bit do_div);
    logic [2:0]  op;
    logic [31:0] a, b, res;
    int          st, k;
    bit          bub;
    logic        wen;
    for (int i = 0; i < count; i++) begin
      a = $urandom;
      b = $urandom;
      op = do_div ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      if (!do_div && i == 0) begin op = 3'd3; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
      else if (do_div && i == 0) begin op = 3'd4; a = 32'hFFFF_FFF9; b = 32'd2; end
      else if (do_div && i == 1) begin op = 3'd6; a = 32'hFFFF_FFF9; b = 32'd2; end
      else if (do_div) begin
        k = $urandom_range(0, 5);
        if (k == 0) b = 32'd0;
        else if (k == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        else if (k == 2) b = $urandom_range(1, 20);
        else if (k == 3) a = $urandom_range(0, 100);
      end
      run_md(op, a, b, res, st, bub, wen);
      total++; if (res !== ref_md(op, a, b)) begin
        bad++; $display("FAIL md_result op=%0d a=%h b=%h got=%h exp=%h", op, a, b, res, ref_md(op, a, b)); end
      total++; if (st != ref_stalls(op, a, b)) begin
        bad++; $display("FAIL md_stalls op=%0d got=%0d exp=%0d", op, st, ref_stalls(op, a, b)); end
      total++; if (!bub || wen !== 1'b1) begin
        bad++; $display("FAIL md_bubble op=%0d bubble_ok=%0d wen=%b exp=1/1", op, bub, wen); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [3];
    logic [31:0] as [3];
    logic [31:0] bs [3];
    logic [31:0] exp [3];
    logic [31:0] res;
    int          st;
    bit          bub;
    logic        wen;
    ops = '{3'd5, 3'd6, 3'd4};
    as  = '{32'd9, 32'd9, 32'h8000_0000};
    bs  = '{32'd0, 32'd0, 32'hFFFF_FFFF};
    exp = '{32'hFFFF_FFFF, 32'd9, 32'h8000_0000};
    for (int i = 0; i < 3; i++) begin
      run_md(ops[i], as[i], bs[i], res, st, bub, wen);
      total++; if (res !== exp[i]) begin bad++; $display("FAIL special_%0d got=%h exp=%h", i, res, exp[i]); end
      total++; if (st != 2) begin bad++; $display("FAIL special_stalls_%0d got=%0d exp=2", i, st); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int          st;
    bit          bub;
    logic        wen;
    @(posedge clk); #1;
    drive(1'b1, 3'd4, ALU_ADD, 32'd1000, 32'd7);
    repeat (11) @(posedge clk);
    #1 flushEX = 1'b1;
    @(negedge clk);
    total++; if (stallEX !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stallEX); end
    @(posedge clk); #1;
    flushEX = 1'b0;
    total++; if (rdWriteEnMEM !== 1'b0) begin bad++; $display("FAIL flush_bubble got=%b exp=0", rdWriteEnMEM); end
    drive(1'b0, 3'd0, ALU_SUB, 32'd3, 32'd5);
    @(negedge clk);
    total++; if (stallEX !== 1'b0) begin bad++; $display("FAIL flush_after_stall got=%b exp=0", stallEX); end
    @(posedge clk); #1;
    total++; if (aluResultMEM !== 32'hFFFF_FFFE) begin bad++; $display("FAIL flush_sub got=%h exp=fffffffe", aluResultMEM); end
    // Flush must also win over an op arriving in IDLE: the op then restarts from scratch.
    drive(1'b1, 3'd0, ALU_ADD, 32'd11, 32'd13);
    flushEX = 1'b1;
    @(posedge clk); #1;
    flushEX = 1'b0;
    st = 0;
    @(negedge clk);
    while (stallEX === 1'b1 && st < 200) begin st++; @(negedge clk); end
    @(posedge clk); #1;
    total++; if (st != 2 || aluResultMEM !== 32'd143) begin
      bad++; $display("FAIL flush_new_op stalls=%0d res=%h exp=2/0000008f", st, aluResultMEM); end
    drive(1'b0, 3'd0, ALU_ADD, 32'd0, 32'd0);
    run_md(3'd0, 32'd6, 32'd7, res, st, bub, wen);
    total++; if (res !== 32'd42 || st != 2) begin bad++; $display("FAIL flush_then_mul got=%0d/%0d exp=42/2", res, st); end
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] res;
    int          st;
    bit          bub;
    logic        wen;
    @(posedge clk); #1;
    drive(1'b1, 3'd5, ALU_ADD, 32'h1234_5678, 32'd3);
    repeat (6) @(posedge clk);
    #1;
    arstn = 1'b0;
    mulDivEnEX = 1'b0;
    #1;
    total++; if ({aluResultMEM, pcPlus4MEM, rdAddrMEM, destinationSelectMEM} !== 71'd0) begin
      bad++; $display("FAIL midreset_outputs got=%h/%h/%0d/%0d exp=0", aluResultMEM, pcPlus4MEM, rdAddrMEM, destinationSelectMEM); end
    total++; if (stallEX !== 1'b0) begin bad++; $display("FAIL midreset_stall got=%b exp=0", stallEX); end
    @(negedge clk);
    arstn = 1'b1;
    run_md(3'd0, 32'd6, 32'd7, res, st, bub, wen);
    total++; if (res !== 32'd42 || st != 2) begin bad++; $display("FAIL midreset_mul got=%0d/%0d exp=42/2", res, st); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op, pop;
    logic [31:0] a, b, pa, pb;
    pop = ALU_ADD; pa = 32'd0; pb = 32'd0;
    for (int i = 0; i < 12; i++) begin
      op = 4'($urandom_range(0, 10)); a = $urandom; b = $urandom;
      @(posedge clk); #1;
      if (i > 0) begin
        total++; if (aluResultMEM !== ref_alu(pop, pa, pb)) begin
          bad++; $display("FAIL b2b_%0d got=%h exp=%h", i, aluResultMEM, ref_alu(pop, pa, pb)); end
      end
      drive(1'b0, 3'd0, op, a, b);
      pop = op; pa = a; pb = b;
      @(negedge clk);
      total++; if (stallEX !== 1'b0) begin bad++; $display("FAIL b2b_stall_%0d got=%b exp=0", i, stallEX); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_muldiv(14, 1'b0);
    test_muldiv(18, 1'b1);
    test_special();
    test_flush();
    test_reset_mid_div();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
